// File: rtl/flash_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : flash_loader_pkg
// Description : Shared types and constants for the boot-time flash loader.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/flash_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_assembler
// Description : Little-endian byte-to-word assembler. Bytes shift in from the
//               top so the first byte of a group ends up in bits [7:0].
//               'word' already includes the byte being shifted this cycle and
//               'full' flags the cycle in which the last byte of a word is
//               taken, so the parent can act on the completed word at that
//               same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_assembler
  import flash_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] word_q;

  // Byte position within the current word; wraps naturally after the last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (shift) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Shift register; older bytes move toward bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (shift) begin
      word_q <= {din, word_q[WIDTH-1:8]};
    end
  end

  assign word = shift ? {din, word_q[WIDTH-1:8]} : word_q;
  assign full = shift && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
// Module      : flash_loader
// Description : Parses a length-prefixed little-endian word image from a byte
//               stream, writes each word through the memory flash port and
//               holds the CPU in reset until the image is complete.
// Options     : FLASH_LOADER_CHECKSUM_EN - append a 4-byte LE checksum (sum of
//               all data words mod 2^WIDTH) that must match for DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MEM_WORDS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_rst
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  loader_state_t    state_q, state_d;
  logic [WIDTH-1:0] n_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] flash_addr_q;
  logic [WIDTH-1:0] flash_data_q;

  logic             w_shift;
  logic             w_start_ok;
  logic             w_full;
  logic [WIDTH-1:0] w_word;
  logic             w_last;

  // A new load may only begin from a quiescent state
  assign w_start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign w_shift    = byte_valid && byte_ready;
  assign w_last     = (WIDTH'(idx_q) + WIDTH'(1)) == n_q;

  byte_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk   (clk),
    .rst   (rst),
    .shift (w_shift),
    .clear (w_start_ok),
    .din   (byte_data),
    .word  (w_word),
    .full  (w_full)
  );

`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam loader_state_t LAST_ST = CSUM;
  logic [WIDTH-1:0] sum_q;

  // Running sum of every word written during the current load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (w_start_ok) begin
      sum_q <= '0;
    end else if (state_q == WRITE) begin
      sum_q <= sum_q + flash_data_q;
    end
  end
`else
  localparam loader_state_t LAST_ST = DONE;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (w_full) begin
          if (w_word == '0)                    state_d = LAST_ST;
          else if (w_word > WIDTH'(MEM_WORDS)) state_d = ERR;
          else                                 state_d = DATA;
        end
      end
      DATA: begin
        if (w_full) state_d = WRITE;
      end
      WRITE: begin
        state_d = w_last ? LAST_ST : DATA;
      end
`ifdef FLASH_LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_full) state_d = (w_word == sum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Word count, write index and the flash port address/data holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q          <= '0;
      idx_q        <= '0;
      flash_addr_q <= '0;
      flash_data_q <= '0;
    end else begin
      if (state_q == LEN && w_full) begin
        n_q   <= w_word;
        idx_q <= '0;
      end
      // Load the port at the 4th byte so it is valid throughout WRITE
      if (state_q == DATA && w_full) begin
        flash_addr_q <= WIDTH'({idx_q, 2'b00});
        flash_data_q <= w_word;
      end
      if (state_q == WRITE) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign byte_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign flash_en   = (state_q == WRITE);
  assign flash_addr = flash_addr_q;
  assign flash_data = flash_data_q;
  assign busy       = (state_q == LEN) || (state_q == DATA) ||
                      (state_q == WRITE) || (state_q == CSUM);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign cpu_rst    = (state_q != DONE);

endmodule
`default_nettype wire

// File: tb/tb_flash_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_loader
// Description : Scoreboard bench for flash_loader. Images are generated from
//               word lists; the expected writes are queued and a monitor
//               compares every flash strobe against that queue.
// Options     : FLASH_LOADER_CHECKSUM_EN - images carry a trailing checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_loader;

  localparam int WIDTH     = 32;
  localparam int MEM_WORDS = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              flash_en;
  logic [WIDTH-1:0]  flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_rst;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks  = 0;
  int          errors  = 0;
  int          strobes = 0;
  logic [31:0] wq[$];

  flash_loader #(.WIDTH(WIDTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flash_en   (flash_en),
    .flash_addr (flash_addr),
    .flash_data (flash_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst    (cpu_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && flash_en === 1'b1) begin
      strobes++;
      check("ready_low_in_write", {31'b0, byte_ready}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_strobe: got strobe addr=0x%08h data=0x%08h, required none",
                 flash_addr, flash_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", flash_addr, mon_e.addr);
        check("strobe_data", flash_data, mon_e.data);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'h0);
    check({tag, "_flash_en"},   {31'b0, flash_en},   32'h0);
    check({tag, "_flash_addr"}, flash_addr,          32'h0);
    check({tag, "_flash_data"}, flash_data,          32'h0);
    check({tag, "_busy"},       {31'b0, busy},       32'h0);
    check({tag, "_done"},       {31'b0, done},       32'h0);
    check({tag, "_err"},        {31'b0, err},        32'h0);
    check({tag, "_cpu_rst"},    {31'b0, cpu_rst},    32'h1);
  endtask

  // Offer bytes; acceptance is decided from byte_ready seen mid-cycle
  task automatic send(input logic [7:0] bq[$], input bit hold);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < bq.size()) begin
      @(negedge clk);
      byte_data  = bq[i];
      byte_valid = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
      start      = hold ? 1'b0 : ($urandom_range(0, 7) == 0);
      acc        = byte_valid && byte_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
      if (guard > 20 * bq.size() + 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, bq.size());
        break;
      end
    end
    start = 1'b0;
  endtask

  // Reference model: build the byte image and the expected outcome from words
  task automatic run_image(input logic [31:0] n, input logic [31:0] words[$],
                           input logic [31:0] csum, input bit hold, input string tag);
    logic [7:0]  bq[$];
    logic [31:0] sum = 32'h0;
    bit          exp_err = 1'b0;
    int          exp_lat = 1;
    int          exp_str = 0;
    int          s0;
    int          lat;
    for (int b = 0; b < 4; b++) bq.push_back(n[8*b +: 8]);
    if (n > MEM_WORDS) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        for (int b = 0; b < 4; b++) bq.push_back(words[i][8*b +: 8]);
        exp_q.push_back('{addr: 32'(i * 4), data: words[i]});
        sum += words[i];
        exp_str++;
      end
`ifdef FLASH_LOADER_CHECKSUM_EN
      for (int b = 0; b < 4; b++) bq.push_back(csum[8*b +: 8]);
      exp_err = (csum != sum);
      exp_lat = 1;
`else
      exp_lat = (n == 0) ? 1 : 2;
`endif
    end
    s0 = strobes;
    // Start together with a junk byte that must not be consumed
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    check({tag, "_busy_after_start"}, {31'b0, busy}, 32'h1);
    send(bq, hold);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(done || err) && lat < 20);
    byte_valid = 1'b0;
    check({tag, "_latency"},    lat,                 exp_lat);
    check({tag, "_done"},       {31'b0, done},       {31'b0, !exp_err});
    check({tag, "_err"},        {31'b0, err},        {31'b0, exp_err});
    check({tag, "_cpu_rst"},    {31'b0, cpu_rst},    {31'b0, exp_err});
    check({tag, "_busy"},       {31'b0, busy},       32'h0);
    check({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'h0);
    check({tag, "_strobes"},    strobes - s0,        exp_str);
    check({tag, "_pending"},    exp_q.size(),        0);
    if (csum == 32'hDEAD_BEEF && sum == 32'h0) ;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s;
    logic [31:0] w;
    logic [31:0] n;
    logic [7:0]  pq[$];
    int          s0;
    int          lat;

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, byte_ready}, 32'h0);

    // Directed two-word image
    wq.delete();
    wq.push_back(32'h1122_3344);
    wq.push_back(32'hAABB_CCDD);
    run_image(2, wq, 32'h1122_3344 + 32'hAABB_CCDD, 1'b0, "two_word");

    // Empty image
    wq.delete();
    run_image(0, wq, 32'h0, 1'b0, "n_zero");

    // Length overflow
    run_image(MEM_WORDS + 1, wq, 32'h0, 1'b0, "n_over");

    // Valid held high across three words
    wq.delete(); s = 0;
    for (int i = 0; i < 3; i++) begin w = $urandom; wq.push_back(w); s += w; end
    run_image(3, wq, s, 1'b1, "hold3");

    // Reset after two of three words, then reload from address 0
    wq.delete(); s = 0;
    for (int i = 0; i < 3; i++) begin w = $urandom; wq.push_back(w); s += w; end
    pq.delete();
    n = 32'd3;
    for (int b = 0; b < 4; b++) pq.push_back(n[8*b +: 8]);
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4; b++) pq.push_back(wq[i][8*b +: 8]);
      exp_q.push_back('{addr: 32'(i * 4), data: wq[i]});
    end
    s0 = strobes;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send(pq, 1'b1);
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (strobes - s0 < 2 && lat < 20);
    check("abort_two_strobes", strobes - s0, 2);
    #1 rst = 1'b1;
    #1 check_reset_values("abort");
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_more_strobes", strobes - s0, 2);
    check("abort_pending", exp_q.size(), 0);
    run_image(3, wq, s, 1'b0, "reload");

    // Largest legal image
    wq.delete(); s = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin w = $urandom; wq.push_back(w); s += w; end
    run_image(MEM_WORDS, wq, s, 1'b1, "n_max");

`ifdef FLASH_LOADER_CHECKSUM_EN
    wq.delete();
    wq.push_back(32'h0000_0001);
    wq.push_back(32'hFFFF_FFFF);
    run_image(2, wq, 32'h0000_0000, 1'b0, "csum_ok");
    run_image(2, wq, 32'h0000_0001, 1'b0, "csum_bad");
`endif

    // Randomised images with random valid gaps and stray start pulses
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      wq.delete(); s = 0;
      for (int i = 0; i < int'(n); i++) begin w = $urandom; wq.push_back(w); s += w; end
      w = ($urandom_range(0, 2) == 0) ? $urandom : s;
      run_image(n, wq, w, bit'($urandom_range(0, 1)), "rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_loader.md
# flash_loader

Boot-time loader that drives the data memory's flash port (`flash_en`/`flash_addr`/`flash_data`) from an incoming byte stream, such as a UART receiver's output. It parses a length-prefixed, little-endian word image and issues one single-cycle flash write per word. It holds the CPU in reset until the image is fully written. It sits between the byte source and the memory block, and owns the CPU reset release.

## Interface
- `WIDTH`, 32, data/address width; must match the memory block.
- `MEM_WORDS`, 2048, word capacity of the RAM (11-bit word index, byte address bits [12:2]).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a load; accepted in IDLE, DONE, ERR.
- `byte_data` in 8: stream byte.
- `byte_valid` in 1: `byte_data` valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `flash_en` out 1: one-cycle write strobe to memory.
- `flash_addr` out WIDTH: byte address, word-aligned (`idx << 2`).
- `flash_data` out WIDTH: assembled word.
- `busy` out 1: high in LEN, DATA, WRITE, CSUM.
- `done` out 1: image loaded successfully.
- `err` out 1: length overflow or checksum mismatch.
- `cpu_rst` out 1: CPU reset hold; low only in DONE.

## Operation
- Stream format: 4-byte LE word count N, then N words, each 4 bytes LE (first byte goes to bits [7:0]).
- A byte is accepted on `byte_valid && byte_ready`.
- States and transitions:
  - IDLE → LEN on `start`.
  - LEN: collect 4 bytes into N.
    - N == 0 → DONE.
    - N > MEM_WORDS → ERR.
    - Otherwise → DATA, with idx = 0.
  - DATA: collect 4 bytes, then → WRITE.
  - WRITE: assert `flash_en` for one cycle with addr = idx<<2, then idx++.
    - idx+1 == N → CSUM (macro on) or DONE.
    - Otherwise → DATA.
  - DONE, ERR: hold until `start` (→ LEN; clears `done`/`err`, re-asserts `cpu_rst`) or `rst`.
- `byte_ready` is 1 only in LEN, DATA, CSUM. It is 0 in IDLE, WRITE, DONE, ERR.
- `start` is ignored while `busy`.
- `start` together with `byte_valid` in IDLE: the byte is not consumed.
- The byte counter is 2 bits and wraps at 4. idx is an 11-bit counter plus a terminal compare against N (N itself is WIDTH bits).
- `flash_addr`/`flash_data` hold their last values outside WRITE; only `flash_en` qualifies them.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `flash_en`=0, `flash_addr`=0, `flash_data`=0, `busy`=0, `done`=0, `err`=0, `cpu_rst`=1.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to any output.
- The 4th byte of a word is accepted at edge k. `flash_en`=1 during cycle k+1. DATA resumes (`byte_ready`=1) in cycle k+2.
- Peak throughput: 1 word per 5 cycles.
- `done`/`cpu_rst` change in the cycle after the final WRITE (macro off) or after the 4th checksum byte (macro on).
- `rst` mid-load aborts immediately. No further `flash_en`. Partial memory contents are left as written.

## Configuration
- `FLASH_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE, enter CSUM and accept 4 LE bytes.
  - Compare against the running sum of all data words mod 2^WIDTH.
  - Equal → DONE. Unequal → ERR.
  - The N == 0 path also goes through CSUM, with an expected value of 0.
- Undefined: no CSUM state and no accumulator; the last WRITE goes straight to DONE.

## Structure
- Package `FLASH_LOADER_PKG`: `loader_state_t` enum (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR) and `BYTES_PER_WORD` = 4.
- Sub-module `byte_assembler`: 2-bit byte counter plus LE shift-in of 8 bits into a WIDTH word. Inputs are `clk`, `rst`, `shift`, `clear`; outputs are `word` and `full`. It is used for LEN, DATA and CSUM.
- `MEM_WORDS` stays a parameter and does not live in the package.

## Test plan
- Two-word image, bytes 02 00 00 00 44 33 22 11 DD CC BB AA:
  - Expect `flash_en` pulses at addr 0x0 with data 0x11223344, then addr 0x4 with data 0xAABBCCDD.
  - Then `done`=1 and `cpu_rst`=0. Exactly 2 strobes.
- N = 0 (macro off): bytes 00 00 00 00 → DONE the cycle after the 4th byte. Zero `flash_en` pulses.
- N = 2049 (01 08 00 00) → `err`=1, `cpu_rst`=1. No `flash_en`. `byte_ready`=0 thereafter.
- `byte_valid` held high continuously: `byte_ready`=0 during every WRITE cycle. No byte is lost or duplicated across 3 words. Addresses are 0x0, 0x4, 0x8.
- `rst` asserted after 2 of 3 words → all outputs at reset values in the same cycle. No strobe afterwards. A new `start` reloads from addr 0.
- With `FLASH_LOADER_CHECKSUM_EN`, words 0x00000001 and 0xFFFFFFFF:
  - Checksum 00 00 00 00 → DONE.
  - Checksum 01 00 00 00 → ERR.
